pipe_ctrl_regs: RTL and testbench

- Pipeline control-register chain ID/EX -> EX/MEM -> MEM/WB for the 5-stage MIPS core.
- Consumes the gated control word, flush and exception signals from the ID-stage controller.
- Produces the registered stage signals the controller's hazard-detection and forwarding logic read back: ID_EX MemRead/Rs/Rt, EX_MEM RegWrite/Rd, MEM_WB RegWrite/Rd.
- Holds only control and register numbers; datapath values live elsewhere.

---
 rtl/pipe_ctrl_regs.sv | 195 +++++++++++++++++++
 tb/tb_pipe_ctrl_regs.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_regs
// Purpose  : ID/EX -> EX/MEM -> MEM/WB control and register-number pipeline.
//            Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_regs #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               id_valid,
    input  logic               RegDst,
    input  logic               Branch,
    input  logic               MemRead,
    input  logic               MemtoReg,
    input  logic               MemWrite,
    input  logic               ALUSrc,
    input  logic               RegWrite,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [REG_AW-1:0]  IF_ID_RegisterRs,
    input  logic [REG_AW-1:0]  IF_ID_RegisterRt,
    input  logic [REG_AW-1:0]  IF_ID_RegisterRd,
    input  logic               EX_Flush,
    output logic               ID_EX_RegDst,
    output logic               ID_EX_ALUSrc,
    output logic               ID_EX_MemRead,
    output logic [ALUOP_W-1:0] ID_EX_ALUOp,
    output logic [REG_AW-1:0]  ID_EX_RegisterRs,
    output logic [REG_AW-1:0]  ID_EX_RegisterRt,
    output logic [REG_AW-1:0]  ID_EX_RegisterRd,
    output logic               EX_MEM_Branch,
    output logic               EX_MEM_MemRead,
    output logic               EX_MEM_MemWrite,
    output logic               EX_MEM_RegWrite,
    output logic               EX_MEM_MemtoReg,
    output logic [REG_AW-1:0]  EX_MEM_RegisterRd,
    output logic               MEM_WB_RegWrite,
    output logic               MEM_WB_MemtoReg,
    output logic [REG_AW-1:0]  MEM_WB_RegisterRd,
    output logic               ex_valid,
    output logic               mem_valid,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]        retired_cnt,
    output logic [31:0]        bubble_cnt,
`endif
    output logic               wb_valid
);

    // ID/EX bank
    logic               r_idExValid;
    logic               r_idExRegDst;
    logic               r_idExBranch;
    logic               r_idExMemRead;
    logic               r_idExMemtoReg;
    logic               r_idExMemWrite;
    logic               r_idExAluSrc;
    logic               r_idExRegWrite;
    logic [ALUOP_W-1:0] r_idExAluOp;
    logic [REG_AW-1:0]  r_idExRs;
    logic [REG_AW-1:0]  r_idExRt;
    logic [REG_AW-1:0]  r_idExRd;

    // EX/MEM bank
    logic               r_exMemValid;
    logic               r_exMemBranch;
    logic               r_exMemMemRead;
    logic               r_exMemMemWrite;
    logic               r_exMemRegWrite;
    logic               r_exMemMemtoReg;
    logic [REG_AW-1:0]  r_exMemRd;

    // MEM/WB bank
    logic               r_memWbValid;
    logic               r_memWbRegWrite;
    logic               r_memWbMemtoReg;
    logic [REG_AW-1:0]  r_memWbRd;

    logic [REG_AW-1:0]  w_resolvedRd;
    logic               w_exRegWrite;

    // A write to $zero is dropped here so forwarding compares never hit it.
    assign w_resolvedRd = r_idExRegDst ? r_idExRd : r_idExRt;
    assign w_exRegWrite = r_idExRegWrite && (w_resolvedRd != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idExValid     <= 1'b0;
            r_idExRegDst    <= 1'b0;
            r_idExBranch    <= 1'b0;
            r_idExMemRead   <= 1'b0;
            r_idExMemtoReg  <= 1'b0;
            r_idExMemWrite  <= 1'b0;
            r_idExAluSrc    <= 1'b0;
            r_idExRegWrite  <= 1'b0;
            r_idExAluOp     <= '0;
            r_idExRs        <= '0;
            r_idExRt        <= '0;
            r_idExRd        <= '0;
            r_exMemValid    <= 1'b0;
            r_exMemBranch   <= 1'b0;
            r_exMemMemRead  <= 1'b0;
            r_exMemMemWrite <= 1'b0;
            r_exMemRegWrite <= 1'b0;
            r_exMemMemtoReg <= 1'b0;
            r_exMemRd       <= '0;
            r_memWbValid    <= 1'b0;
            r_memWbRegWrite <= 1'b0;
            r_memWbMemtoReg <= 1'b0;
            r_memWbRd       <= '0;
        end else if (!hold) begin
            r_idExValid     <= id_valid;
            r_idExRegDst    <= RegDst;
            r_idExBranch    <= Branch;
            r_idExMemRead   <= MemRead;
            r_idExMemtoReg  <= MemtoReg;
            r_idExMemWrite  <= MemWrite;
            r_idExAluSrc    <= ALUSrc;
            r_idExRegWrite  <= RegWrite;
            r_idExAluOp     <= ALUOp;
            r_idExRs        <= IF_ID_RegisterRs;
            r_idExRt        <= IF_ID_RegisterRt;
            r_idExRd        <= IF_ID_RegisterRd;

            if (EX_Flush) begin
                r_exMemValid    <= 1'b0;
                r_exMemBranch   <= 1'b0;
                r_exMemMemRead  <= 1'b0;
                r_exMemMemWrite <= 1'b0;
                r_exMemRegWrite <= 1'b0;
                r_exMemMemtoReg <= 1'b0;
                r_exMemRd       <= '0;
            end else begin
                r_exMemValid    <= r_idExValid;
                r_exMemBranch   <= r_idExBranch;
                r_exMemMemRead  <= r_idExMemRead;
                r_exMemMemWrite <= r_idExMemWrite;
                r_exMemRegWrite <= w_exRegWrite;
                r_exMemMemtoReg <= r_idExMemtoReg;
                r_exMemRd       <= w_resolvedRd;
            end

            r_memWbValid    <= r_exMemValid;
            r_memWbRegWrite <= r_exMemRegWrite;
            r_memWbMemtoReg <= r_exMemMemtoReg;
            r_memWbRd       <= r_exMemRd;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_retiredCnt;
    logic [31:0] r_bubbleCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retiredCnt <= '0;
            r_bubbleCnt  <= '0;
        end else if (!hold) begin
            if (r_memWbValid) begin
                r_retiredCnt <= r_retiredCnt + 32'd1;
            end else begin
                r_bubbleCnt  <= r_bubbleCnt + 32'd1;
            end
        end
    end

    assign retired_cnt = r_retiredCnt;
    assign bubble_cnt  = r_bubbleCnt;
`endif

    assign ID_EX_RegDst      = r_idExRegDst;
    assign ID_EX_ALUSrc      = r_idExAluSrc;
    assign ID_EX_MemRead     = r_idExMemRead;
    assign ID_EX_ALUOp       = r_idExAluOp;
    assign ID_EX_RegisterRs  = r_idExRs;
    assign ID_EX_RegisterRt  = r_idExRt;
    assign ID_EX_RegisterRd  = r_idExRd;
    assign EX_MEM_Branch     = r_exMemBranch;
    assign EX_MEM_MemRead    = r_exMemMemRead;
    assign EX_MEM_MemWrite   = r_exMemMemWrite;
    assign EX_MEM_RegWrite   = r_exMemRegWrite;
    assign EX_MEM_MemtoReg   = r_exMemMemtoReg;
    assign EX_MEM_RegisterRd = r_exMemRd;
    assign MEM_WB_RegWrite   = r_memWbRegWrite;
    assign MEM_WB_MemtoReg   = r_memWbMemtoReg;
    assign MEM_WB_RegisterRd = r_memWbRd;
    assign ex_valid          = r_idExValid;
    assign mem_valid         = r_exMemValid;
    assign wb_valid          = r_memWbValid;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_regs
// Purpose  : Table-driven self-checking bench for pipe_ctrl_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_regs;

    logic       clk = 1'b0;
    logic       rst_n, hold, id_valid, EX_Flush;
    logic       RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0] ALUOp;
    logic [4:0] IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd;
    logic       ID_EX_RegDst, ID_EX_ALUSrc, ID_EX_MemRead;
    logic [1:0] ID_EX_ALUOp;
    logic [4:0] ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd;
    logic       EX_MEM_Branch, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg;
    logic [4:0] EX_MEM_RegisterRd;
    logic       MEM_WB_RegWrite, MEM_WB_MemtoReg;
    logic [4:0] MEM_WB_RegisterRd;
    logic       ex_valid, mem_valid, wb_valid;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] retired_cnt, bubble_cnt;
`endif

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl_regs #(.REG_AW(5), .ALUOP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid),
        .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .IF_ID_RegisterRd(IF_ID_RegisterRd), .EX_Flush(EX_Flush),
        .ID_EX_RegDst(ID_EX_RegDst), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_RegisterRs(ID_EX_RegisterRs),
        .ID_EX_RegisterRt(ID_EX_RegisterRt), .ID_EX_RegisterRd(ID_EX_RegisterRd),
        .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_MemtoReg(EX_MEM_MemtoReg), .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemtoReg(MEM_WB_MemtoReg),
        .MEM_WB_RegisterRd(MEM_WB_RegisterRd),
        .ex_valid(ex_valid), .mem_valid(mem_valid),
`ifdef PIPE_PERF_CNT_EN
        .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt),
`endif
        .wb_valid(wb_valid)
    );

    // expMem = {valid, Branch, MemRead, MemWrite, RegWrite, MemtoReg, Rd}
    // as the entry should look once it reaches EX/MEM (hand-computed).
    typedef struct {
        logic        v, regDst, branch, memRead, memtoReg, memWrite, aluSrc, regWrite;
        logic [1:0]  aluOp;
        logic [4:0]  rs, rt, rd;
        logic        kill;
        logic [10:0] expMem;
    } vec_t;

    localparam int N = 11;
    vec_t vecs [N];

    function automatic logic [20:0] idPack(input vec_t x);
        return {x.v, x.regDst, x.aluSrc, x.memRead, x.aluOp, x.rs, x.rt, x.rd};
    endfunction

    function automatic logic [7:0] wbOf(input logic [10:0] m);
        return {m[10], m[6], m[5], m[4:0]};
    endfunction

    function automatic logic [20:0] actId();
        return {ex_valid, ID_EX_RegDst, ID_EX_ALUSrc, ID_EX_MemRead, ID_EX_ALUOp,
                ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd};
    endfunction

    function automatic logic [10:0] actMem();
        return {mem_valid, EX_MEM_Branch, EX_MEM_MemRead, EX_MEM_MemWrite,
                EX_MEM_RegWrite, EX_MEM_MemtoReg, EX_MEM_RegisterRd};
    endfunction

    function automatic logic [7:0] actWb();
        return {wb_valid, MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_RegisterRd};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string name, input logic [20:0] eId,
                            input logic [10:0] eMem, input logic [7:0] eWb);
        check({name, " id_ex"},  {11'd0, actId()}, {11'd0, eId});
        check({name, " ex_mem"}, {21'd0, actMem()}, {21'd0, eMem});
        check({name, " mem_wb"}, {24'd0, actWb()}, {24'd0, eWb});
    endtask

    task automatic drive(input vec_t x, input logic flush);
        id_valid = x.v;        RegDst = x.regDst;     Branch = x.branch;
        MemRead = x.memRead;   MemtoReg = x.memtoReg; MemWrite = x.memWrite;
        ALUSrc = x.aluSrc;     RegWrite = x.regWrite; ALUOp = x.aluOp;
        IF_ID_RegisterRs = x.rs; IF_ID_RegisterRt = x.rt; IF_ID_RegisterRd = x.rd;
        EX_Flush = flush;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            v     dst   br    mr    m2r   mw    as    rw    op     rs     rt     rd     kill  expMem
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,5'd1, 5'd2, 5'd5, 1'b0,11'b1_0_0_0_1_0_00101};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,5'd4, 5'd9, 5'd3, 1'b0,11'b1_0_0_0_1_0_01001};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,5'd3, 5'd6, 5'd0, 1'b0,11'b1_0_0_0_0_0_00000};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,2'b00,5'd2, 5'd7, 5'd0, 1'b1,11'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,5'd8, 5'd10,5'd0, 1'b1,11'b0};
        vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,5'd11,5'd12,5'd0, 1'b0,11'b1_1_0_0_0_0_01100};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0, 5'd0, 5'd0, 1'b0,11'b0};
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,5'd13,5'd14,5'd15,1'b0,11'b1_0_0_0_1_0_01111};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,2'b00,5'd1, 5'd31,5'd0, 1'b0,11'b1_0_1_0_1_1_11111};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0, 5'd0, 5'd0, 1'b0,11'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0, 5'd0, 5'd0, 1'b0,11'b0};

        // Reset with random inputs; second edge also asserts hold and flush.
        rst_n = 1'b0;
        hold  = 1'b0;
        {id_valid, RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite} = 8'($urandom);
        ALUOp = 2'($urandom);
        IF_ID_RegisterRs = 5'($urandom);
        IF_ID_RegisterRt = 5'($urandom);
        IF_ID_RegisterRd = 5'($urandom);
        EX_Flush = 1'b0;
        step();
        hold = 1'b1;
        EX_Flush = 1'b1;
        step();
        checkAll("reset", 21'd0, 11'd0, 8'd0);
`ifdef PIPE_PERF_CNT_EN
        check("reset retired_cnt", retired_cnt, 32'd0);
        check("reset bubble_cnt", bubble_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        hold  = 1'b0;

        for (int i = 0; i < N; i++) begin
            drive(vecs[i], (i > 0) ? vecs[i-1].kill : 1'b0);
            step();
            check($sformatf("vec%0d id_ex", i), {11'd0, actId()}, {11'd0, idPack(vecs[i])});
            if (i >= 1)
                check($sformatf("vec%0d ex_mem", i - 1), {21'd0, actMem()}, {21'd0, vecs[i-1].expMem});
            if (i >= 2)
                check($sformatf("vec%0d mem_wb", i - 2), {24'd0, actWb()}, {24'd0, wbOf(vecs[i-2].expMem)});
        end
`ifdef PIPE_PERF_CNT_EN
        check("perf retired_cnt", retired_cnt, 32'd5);
        check("perf bubble_cnt", bubble_cnt, 32'd6);
`endif

        // Fill all stages, then freeze for 3 cycles with flush and new inputs.
        drive(vecs[0], 1'b0); step();
        drive(vecs[1], 1'b0); step();
        drive(vecs[5], 1'b0); step();
        checkAll("prehold", idPack(vecs[5]), vecs[1].expMem, wbOf(vecs[0].expMem));
        hold = 1'b1;
        drive(vecs[8], 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            checkAll($sformatf("hold%0d", c), idPack(vecs[5]), vecs[1].expMem, wbOf(vecs[0].expMem));
        end
        hold = 1'b0;
        drive(vecs[8], 1'b0); step();
        checkAll("resume0", idPack(vecs[8]), vecs[5].expMem, wbOf(vecs[1].expMem));
        drive(vecs[0], 1'b0); step();
        checkAll("resume1", idPack(vecs[0]), vecs[8].expMem, wbOf(vecs[5].expMem));

        // Mid-stream reset wins over hold and flush.
        rst_n = 1'b0;
        hold  = 1'b1;
        drive(vecs[1], 1'b1);
        step();
        checkAll("midreset", 21'd0, 11'd0, 8'd0);
`ifdef PIPE_PERF_CNT_EN
        check("midreset retired_cnt", retired_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        hold  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
